// File: rtl/ir_pipe.sv
// ir_pipe: buffered instruction register between fetch and execute.
// Instruction words arrive over a valid/ready handshake and wait in a small
// prefetch queue. The head word is decoded and held in a registered output
// stage with its own valid/ready handshake.
// Optional feature macro: IR_PARITY_EN adds the iParity input and a per-word
// even-parity error flag that is delivered on oParityErr.
module ir_pipe #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CD_W   = 4,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2,
    parameter logic [OP_W-1:0] BRA_OP = 4'b0001,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iFlush,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iInstruction,
`ifdef IR_PARITY_EN
    input  logic              iParity,
`endif
    output logic              oReady,
    output logic              oValid,
    input  logic              iReady,
    output logic [OP_W-1:0]   oOpcode,
    output logic [CD_W-1:0]   oCDcode,
    output logic              oIsBranch,
    output logic              osrcType,
    output logic              odestType,
    output logic [ADDR_W-1:0] osrc1,
    output logic [ADDR_W-1:0] osrc2,
    output logic              oParityErr,
    output logic [LVL_W-1:0]  oLevel
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic              accept;
    logic              consume;
    logic              load_slot;
    logic              q_empty;
    logic              pop;
    logic              bypass;
    logic              push;
    logic [DATA_W-1:0] load_word;
    logic [OP_W-1:0]   load_op;
    logic [CD_W-1:0]   load_cd;
    logic              load_br;

    // Handshakes and output-stage load decision; the bypass path is only used
    // when the queue is empty, which keeps delivery strictly in order.
    assign oReady    = !iReset && (level < DEPTH_L);
    assign oLevel    = level;
    assign accept    = iValid && oReady;
    assign consume   = oValid && iReady;
    assign load_slot = !oValid || consume;
    assign q_empty   = (level == '0);
    assign pop       = load_slot && !q_empty;
    assign bypass    = load_slot && q_empty && accept;
    assign push      = accept && !bypass;

    // Field extraction of the word about to enter the output stage.
    assign load_word = q_empty ? iInstruction : mem[rd_ptr];
    assign load_op   = load_word[DATA_W-1 -: OP_W];
    assign load_cd   = load_word[DATA_W-OP_W-1 -: CD_W];
    assign load_br   = (load_op == BRA_OP);

    // Queue storage; stale entries are harmless because pointers gate reads.
    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= iInstruction;
        end
    end

    // Pointers, occupancy and the registered decode stage.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            oValid    <= 1'b0;
            oOpcode   <= '0;
            oCDcode   <= '0;
            oIsBranch <= 1'b0;
            osrcType  <= 1'b0;
            odestType <= 1'b0;
            osrc1     <= '0;
            osrc2     <= '0;
        end else if (iFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            oValid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (load_slot) begin
                oValid <= pop || bypass;
                if (pop || bypass) begin
                    oOpcode   <= load_op;
                    oCDcode   <= load_br ? load_cd : '0;
                    oIsBranch <= load_br;
                    osrcType  <= load_word[DATA_W-OP_W-1];
                    odestType <= load_word[DATA_W-OP_W-2];
                    osrc1     <= load_word[2*ADDR_W-1:ADDR_W];
                    osrc2     <= load_word[ADDR_W-1:0];
                end
            end
        end
    end

`ifdef IR_PARITY_EN
    logic err_mem [DEPTH];
    logic in_err;
    logic load_err;

    assign in_err   = ^{iInstruction, iParity};
    assign load_err = q_empty ? in_err : err_mem[rd_ptr];

    // Per-entry parity error, queued alongside its word.
    always_ff @(posedge iClk) begin
        if (push) begin
            err_mem[wr_ptr] <= in_err;
        end
    end

    // Parity flag travels with the presented word; bad words still go out.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oParityErr <= 1'b0;
        end else if (!iFlush && load_slot && (pop || bypass)) begin
            oParityErr <= load_err;
        end
    end
`else
    assign oParityErr = 1'b0;
`endif

endmodule
